// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debouncer family.
// The counter action enum names the three things a stability counter can do on an edge.
package debounce_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;

    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_FLIP  = 2'd2
    } cnt_action_e;

    // Bits needed to hold values 0..max_val, i.e. clog2(max_val+1), never less than 1.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser chain, stability counter, debounced level
// and registered one-cycle rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in_n,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt;
    cnt_action_e            action;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_n};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Any sample that agrees with the current level restarts the count.
    always_comb begin
        action = ACT_IDLE;
        if (synced != level) begin
            if (cnt == CNT_LAST) begin
                action = ACT_FLIP;
            end else begin
                action = ACT_COUNT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (action)
                ACT_COUNT: begin
                    cnt <= cnt + CNT_W'(1);
                end
                ACT_FLIP: begin
                    cnt   <= '0;
                    level <= synced;
                    rise  <= synced;
                    fall  <= ~synced;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: independent channels side by side, plus a
// combined rising-edge flag for interrupt-style consumers.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_n,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_rise
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .in_n (in_n[g]),
            .level(level[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

    assign any_rise = |rise;

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: a default-style instance and a short-filter
// instance, each shadowed by a sliding-window model of the debounce rule.
module tb_debouncer_multi;

    localparam int A_CH = 4, A_SYNC = 2, A_STABLE = 4;
    localparam int B_CH = 2, B_SYNC = 3, B_STABLE = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [A_CH-1:0] inA = '0;
    logic [B_CH-1:0] inB = '0;
    logic [A_CH-1:0] levelA, riseA, fallA;
    logic [B_CH-1:0] levelB, riseB, fallB;
    logic            anyRiseA, anyRiseB;

    int checkCount = 0;
    int passCount  = 0;
    bit started    = 1'b0;

    debouncer_multi #(.CHANNELS(A_CH), .SYNC_STAGES(A_SYNC), .STABLE_CYCLES(A_STABLE)) dutA (
        .clk(clk), .rst(rst), .in_n(inA),
        .level(levelA), .rise(riseA), .fall(fallA), .any_rise(anyRiseA)
    );

    debouncer_multi #(.CHANNELS(B_CH), .SYNC_STAGES(B_SYNC), .STABLE_CYCLES(B_STABLE)) dutB (
        .clk(clk), .rst(rst), .in_n(inB),
        .level(levelB), .rise(riseB), .fall(fallB), .any_rise(anyRiseB)
    );

    always #5 clk = ~clk;

    // hist[0] is the input sampled at this edge; the value the level logic sees
    // at this edge is hist[sync]. A level flips once the last `stable` such
    // values all differ from it.
    function automatic logic [3:0] modelLevel(input logic [15:0][3:0] hist, input int sync,
                                              input int stable, input logic [3:0] lvl);
        logic [3:0] nxt;
        nxt = lvl;
        for (int c = 0; c < 4; c++) begin
            bit allDiff;
            allDiff = 1'b1;
            for (int k = 0; k < stable; k++) begin
                if (hist[sync + k][c] == lvl[c]) allDiff = 1'b0;
            end
            if (allDiff) nxt[c] = ~lvl[c];
        end
        return nxt;
    endfunction

    logic [15:0][3:0] histA, histB;
    logic [3:0] expLevelA, expRiseA, expFallA;
    logic [3:0] expLevelB, expRiseB, expFallB;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            histA     <= '0;
            histB     <= '0;
            expLevelA <= '0;
            expRiseA  <= '0;
            expFallA  <= '0;
            expLevelB <= '0;
            expRiseB  <= '0;
            expFallB  <= '0;
        end else begin
            histA     <= {histA[14:0], inA};
            histB     <= {histB[14:0], {2'b00, inB}};
            expLevelA <= modelLevel({histA[14:0], inA}, A_SYNC, A_STABLE, expLevelA);
            expRiseA  <= modelLevel({histA[14:0], inA}, A_SYNC, A_STABLE, expLevelA) & ~expLevelA;
            expFallA  <= ~modelLevel({histA[14:0], inA}, A_SYNC, A_STABLE, expLevelA) & expLevelA;
            expLevelB <= modelLevel({histB[14:0], {2'b00, inB}}, B_SYNC, B_STABLE, expLevelB);
            expRiseB  <= modelLevel({histB[14:0], {2'b00, inB}}, B_SYNC, B_STABLE, expLevelB) & ~expLevelB;
            expFallB  <= ~modelLevel({histB[14:0], {2'b00, inB}}, B_SYNC, B_STABLE, expLevelB) & expLevelB;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs are compared against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("model levelA", levelA, expLevelA);
            checkOutput("model riseA", riseA, expRiseA);
            checkOutput("model fallA", fallA, expFallA);
            checkOutput("model anyRiseA", anyRiseA, |expRiseA);
            checkOutput("model levelB", levelB, expLevelB[1:0]);
            checkOutput("model riseB", riseB, expRiseB[1:0]);
            checkOutput("model fallB", fallB, expFallB[1:0]);
            checkOutput("model anyRiseB", anyRiseB, |expRiseB);
        end
    end

    task automatic applyStimulus(input logic [A_CH-1:0] a, input logic [B_CH-1:0] b);
        @(negedge clk);
        inA = a;
        inB = b;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        rst     = 1'b1;
        inA     = 4'hF;
        started = 1'b1;
        waitEdges(3);
        checkOutput("reset levelA", levelA, 4'h0);
        checkOutput("reset riseA", riseA, 4'h0);
        checkOutput("reset fallA", fallA, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        waitEdges(5);
        checkOutput("release levelA edge5", levelA, 4'h0);
        waitEdges(1);
        checkOutput("release levelA edge6", levelA, 4'hF);
        checkOutput("release riseA edge6", riseA, 4'hF);
        checkOutput("release anyRiseA edge6", anyRiseA, 1'b1);
        waitEdges(1);
        checkOutput("release riseA edge7", riseA, 4'h0);

        applyStimulus(4'h0, 2'b00);
        waitEdges(8);
        checkOutput("all low levelA", levelA, 4'h0);

        // Clean press on channel 0.
        applyStimulus(4'b0001, 2'b00);
        waitEdges(5);
        checkOutput("press levelA edge5", levelA, 4'b0000);
        waitEdges(1);
        checkOutput("press levelA edge6", levelA, 4'b0001);
        checkOutput("press riseA edge6", riseA, 4'b0001);
        waitEdges(1);
        checkOutput("press riseA edge7", riseA, 4'b0000);

        // Three-cycle glitch on channel 1 must be rejected.
        applyStimulus(4'b0011, 2'b00);
        repeat (2) applyStimulus(4'b0011, 2'b00);
        applyStimulus(4'b0001, 2'b00);
        waitEdges(8);
        checkOutput("glitch3 levelA", levelA, 4'b0001);

        // Four-cycle pulse on channel 1 just makes it through.
        applyStimulus(4'b0011, 2'b00);
        repeat (3) applyStimulus(4'b0011, 2'b00);
        applyStimulus(4'b0001, 2'b00);
        waitEdges(2);
        checkOutput("pulse4 levelA edge6", levelA, 4'b0011);
        checkOutput("pulse4 riseA edge6", riseA, 4'b0010);
        waitEdges(3);
        checkOutput("pulse4 levelA edge9", levelA, 4'b0011);
        waitEdges(1);
        checkOutput("pulse4 levelA edge10", levelA, 4'b0001);
        checkOutput("pulse4 fallA edge10", fallA, 4'b0010);

        // Bouncing channel 2 settles high after its last transition.
        applyStimulus(4'b0101, 2'b00);
        applyStimulus(4'b0001, 2'b00);
        applyStimulus(4'b0101, 2'b00);
        applyStimulus(4'b0001, 2'b00);
        applyStimulus(4'b0101, 2'b00);
        waitEdges(5);
        checkOutput("bounce levelA edge9", levelA, 4'b0001);
        waitEdges(1);
        checkOutput("bounce levelA edge10", levelA, 4'b0101);
        checkOutput("bounce riseA edge10", riseA, 4'b0100);

        // Reset in the middle of channel 3 counting.
        applyStimulus(4'b1101, 2'b00);
        applyStimulus(4'b1101, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async reset levelA", levelA, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        waitEdges(5);
        checkOutput("midreset levelA edge5", levelA, 4'b0000);
        waitEdges(1);
        checkOutput("midreset levelA edge6", levelA, 4'b1101);
        checkOutput("midreset riseA edge6", riseA, 4'b1101);

        // Short-filter instance: a one-cycle pulse passes straight through.
        applyStimulus(4'b1101, 2'b01);
        applyStimulus(4'b1101, 2'b00);
        waitEdges(2);
        checkOutput("short levelB edge3", levelB, 2'b00);
        waitEdges(1);
        checkOutput("short levelB edge4", levelB, 2'b01);
        checkOutput("short riseB edge4", riseB, 2'b01);
        checkOutput("short fallB edge4", fallB, 2'b00);
        waitEdges(1);
        checkOutput("short levelB edge5", levelB, 2'b00);
        checkOutput("short riseB edge5", riseB, 2'b00);
        checkOutput("short fallB edge5", fallB, 2'b01);
        waitEdges(1);
        checkOutput("short fallB edge6", fallB, 2'b00);

        waitEdges(4);
        started = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
